// File: rtl/osc_bank_pkg.sv
// Shared constants for the oscillator bank: control-bit layout, noise LFSR shape and output taps.
// Latency: n/a (declarations only). Backpressure: n/a.
// Noise constants are only consumed when OSC_BANK_NOISE_EN is defined.
package osc_bank_pkg;

   localparam int CTRL_SYNC  = 1;
   localparam int CTRL_RING  = 2;
   localparam int CTRL_TEST  = 3;
   localparam int CTRL_TRI   = 4;
   localparam int CTRL_SAW   = 5;
   localparam int CTRL_PULSE = 6;
   localparam int CTRL_NOISE = 7;

   // Field order mirrors the CTRL_* indices, MSB first.
   typedef struct packed {
      logic noise;
      logic pulse;
      logic sawtooth;
      logic triangle;
      logic test;
      logic ring;
      logic sync;
      logic rsvd;
   } ctrl_t;

   localparam int                LFSR_W     = 23;
   localparam logic [LFSR_W-1:0] LFSR_SEED  = 23'h7FFFFF;
   localparam int                LFSR_TAP_A = 22;
   localparam int                LFSR_TAP_B = 17;

   localparam int NOISE_TAPS [8] = '{20, 18, 14, 11, 9, 5, 2, 0};

   function automatic logic [7:0] noise_bits(input logic [LFSR_W-1:0] lfsr);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[7-i] = lfsr[NOISE_TAPS[i]];
      return r;
   endfunction

endpackage

// File: rtl/osc_voice.sv
// One oscillator voice: phase accumulator, optional noise LFSR (OSC_BANK_NOISE_EN), waveform AND-combine.
// Latency: wave is registered every clk from current state (1 clk). Backpressure: none; state moves only on tick.
// msb_rise is combinational from registered state, so chaining voices for sync forms no loop.
module osc_voice
   import osc_bank_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int OUT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [15:0]      freq,
   input  logic [11:0]      pulse_width,
   input  logic [7:0]       ctrl,
   input  logic             src_msb,
   input  logic             src_msb_rise,
   output logic             msb,
   output logic             msb_rise,
   output logic [OUT_W-1:0] wave
);

   ctrl_t c;
   assign c = ctrl_t'(ctrl);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0] acc_nxt;

   assign acc_sum  = acc + {{(ACC_W-16){1'b0}}, freq};
   assign msb      = acc[ACC_W-1];
   // A source held in test never reports a rise.
   assign msb_rise = tick & ~c.test & ~acc[ACC_W-1] & acc_sum[ACC_W-1];

   always_comb begin
      acc_nxt = acc_sum;
      if (c.test || (c.sync && src_msb_rise)) acc_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst)       acc <= '0;
      else if (tick) acc <= acc_nxt;
   end

   logic [OUT_W-1:0] noise_w;
   logic             noise_on;
   logic             unused_ctrl;

`ifdef OSC_BANK_NOISE_EN
   logic [LFSR_W-1:0] lfsr;
   logic              lfsr_step;

   assign lfsr_step = ~acc[ACC_W-5] & acc_nxt[ACC_W-5];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (tick) begin
         if (c.test)         lfsr <= LFSR_SEED;
         else if (lfsr_step) lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
      end
   end

   always_comb begin
      noise_w = '0;
      noise_w[OUT_W-1 -: 8] = noise_bits(lfsr);
   end
   assign noise_on    = c.noise;
   assign unused_ctrl = c.rsvd;
`else
   assign noise_w     = '0;
   assign noise_on    = 1'b0;
   assign unused_ctrl = c.rsvd ^ c.noise;
`endif

   logic             fold;
   logic [OUT_W-1:0] tri_w;
   logic [OUT_W-1:0] saw_w;
   logic [OUT_W-1:0] pulse_w;
   logic [OUT_W-1:0] wave_nxt;

   assign fold    = acc[ACC_W-1] ^ (c.ring & src_msb);
   assign tri_w   = {acc[ACC_W-2 -: OUT_W-1] ^ {(OUT_W-1){fold}}, 1'b0};
   assign saw_w   = acc[ACC_W-1 -: OUT_W];
   assign pulse_w = (c.test || (acc[ACC_W-1 -: 12] >= pulse_width)) ? '1 : '0;

   always_comb begin
      wave_nxt = '1;
      if (c.triangle) wave_nxt = wave_nxt & tri_w;
      if (c.sawtooth) wave_nxt = wave_nxt & saw_w;
      if (c.pulse)    wave_nxt = wave_nxt & pulse_w;
      if (noise_on)   wave_nxt = wave_nxt & noise_w;
      if (!(c.triangle || c.sawtooth || c.pulse || noise_on)) wave_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) wave <= '0;
      else     wave <= wave_nxt;
   end

endmodule

// File: rtl/osc_bank.sv
// Bank of NUM_VOICES oscillators with ring-ordered hard sync / ring mod; noise path gated by OSC_BANK_NOISE_EN.
// Latency: o_wave registered 1 clk after state. Backpressure: none; state advances only on clk_1mhz_ph1_en.
module osc_bank
   import osc_bank_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int ACC_W      = 24,
   parameter int OUT_W      = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_1mhz_ph1_en,
   input  logic [NUM_VOICES*16-1:0]    i_frequency,
   input  logic [NUM_VOICES*12-1:0]    i_pulse_width,
   input  logic [NUM_VOICES*8-1:0]     i_ctrl,
   output logic [NUM_VOICES*OUT_W-1:0] o_wave,
   output logic [7:0]                  o_osc_last
);

   logic [NUM_VOICES-1:0] msb;
   logic [NUM_VOICES-1:0] msb_rise;
   logic [NUM_VOICES-1:0] src_msb;
   logic [NUM_VOICES-1:0] src_rise;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      // Voice v is driven by voice v-1, wrapping voice 0 back to the last one.
      localparam int SRC = (v + NUM_VOICES - 1) % NUM_VOICES;

      assign src_msb[v]  = msb[SRC];
      assign src_rise[v] = msb_rise[SRC];

      osc_voice #(
         .ACC_W (ACC_W),
         .OUT_W (OUT_W)
      ) u_voice (
         .clk          (clk),
         .rst          (rst),
         .tick         (clk_1mhz_ph1_en),
         .freq         (i_frequency[v*16 +: 16]),
         .pulse_width  (i_pulse_width[v*12 +: 12]),
         .ctrl         (i_ctrl[v*8 +: 8]),
         .src_msb      (src_msb[v]),
         .src_msb_rise (src_rise[v]),
         .msb          (msb[v]),
         .msb_rise     (msb_rise[v]),
         .wave         (o_wave[v*OUT_W +: OUT_W])
      );
   end

   assign o_osc_last = o_wave[NUM_VOICES*OUT_W-1 -: 8];

endmodule

// File: tb/tb_osc_bank.sv
// Directed bench for osc_bank; expected values are queued by the stimulus and checked by a negedge monitor.
module tb_osc_bank;
   localparam int NV = 3;
   localparam int AW = 24;
   localparam int OW = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [NV*16-1:0] freq;
   logic [NV*12-1:0] pw;
   logic [NV*8-1:0]  ctrl;
   logic [NV*OW-1:0] wave;
   logic [7:0]       last;

   always #5 clk = ~clk;

   osc_bank #(.NUM_VOICES(NV), .ACC_W(AW), .OUT_W(OW)) dut (
      .clk             (clk),
      .rst             (rst),
      .clk_1mhz_ph1_en (en),
      .i_frequency     (freq),
      .i_pulse_width   (pw),
      .i_ctrl          (ctrl),
      .o_wave          (wave),
      .o_osc_last      (last)
   );

   typedef struct {
      string       name;
      int          voice;   // -1 selects o_osc_last
      logic [11:0] exp;
   } exp_t;

   exp_t sb[$];
   logic sample_vld = 1'b0;
   int   n_checks   = 0;
   int   n_fail     = 0;

   always @(negedge clk) begin
      exp_t        e;
      logic [11:0] got;
      if (sample_vld) begin
         while (sb.size() != 0) begin
            e   = sb.pop_front();
            got = (e.voice < 0) ? {4'h0, last} : wave[e.voice*OW +: OW];
            n_checks++;
            if (got !== e.exp) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
         end
      end
   end

   task automatic expect_w(input string name, input int v, input logic [11:0] e);
      sb.push_back('{name, v, e});
   endtask

   task automatic sample();
      sample_vld = 1'b1;
      @(negedge clk);
      #1 sample_vld = 1'b0;
   endtask

   task automatic ticks(input int n);
      en = 1'b1;
      repeat (n) @(posedge clk);
      #1 en = 1'b0;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_v(input int v, input logic [15:0] f, input logic [11:0] p, input logic [7:0] c);
      freq[v*16 +: 16] = f;
      pw[v*12 +: 12]   = p;
      ctrl[v*8 +: 8]   = c;
   endtask

   task automatic fresh();
      freq = '0;
      pw   = '0;
      ctrl = '0;
      rst  = 1'b1;
      en   = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      en = 1'b0;
   endtask

   initial begin
      // Reset held with ticks running and nonzero inputs.
      rst  = 1'b1;
      en   = 1'b1;
      freq = {16'h1234, 16'h4321, 16'h1000};
      pw   = '0;
      ctrl = {8'h20, 8'h20, 8'h20};
      repeat (3) @(posedge clk);
      #1;
      expect_w("rst_v0", 0, 12'h000);
      expect_w("rst_v1", 1, 12'h000);
      expect_w("rst_v2", 2, 12'h000);
      expect_w("rst_last", -1, 12'h000);
      sample();

      // Sawtooth ramp, tick gating and wrap.
      fresh();
      set_v(0, 16'h1000, 12'h000, 8'h20);
      ticks(256);
      settle();
      expect_w("saw_256", 0, 12'h100);
      expect_w("v1_idle", 1, 12'h000);
      sample();
      repeat (10) @(posedge clk);
      #1;
      expect_w("tick_gate", 0, 12'h100);
      sample();
      ticks(3840);
      settle();
      expect_w("saw_wrap", 0, 12'h000);
      sample();

      // Pulse threshold and test bit.
      fresh();
      set_v(0, 16'h1000, 12'h800, 8'h40);
      ticks(2047);
      settle();
      expect_w("pulse_below", 0, 12'h000);
      sample();
      ticks(1);
      settle();
      expect_w("pulse_at", 0, 12'hFFF);
      sample();
      ctrl[7:0] = 8'h48;
      settle();
      expect_w("pulse_test", 0, 12'hFFF);
      sample();
      ticks(5);
      ctrl[7:0] = 8'h28;
      settle();
      expect_w("test_acc_frozen", 0, 12'h000);
      sample();
      ctrl[7:0] = 8'h20;
      ticks(1);
      settle();
      expect_w("test_release", 0, 12'h001);
      sample();

      // Hard sync: voice1 offset so a missed sync is visible at tick 32768.
      fresh();
      set_v(0, 16'h0100, 12'h000, 8'h20);
      set_v(1, 16'h3000, 12'h000, 8'h22);
      ticks(1);
      freq[31:16] = 16'h1000;
      ticks(32766);
      settle();
      expect_w("sync_before", 1, 12'h001);
      sample();
      ticks(1);
      settle();
      expect_w("sync_src", 0, 12'h800);
      expect_w("sync_reset", 1, 12'h000);
      sample();
      ticks(1);
      settle();
      expect_w("sync_after", 1, 12'h001);
      sample();

      // Ring modulation, readback and AND combine.
      fresh();
      set_v(0, 16'h8000, 12'h000, 8'h00);
      set_v(1, 16'h1000, 12'h000, 8'h14);
      set_v(2, 16'h1000, 12'h000, 8'h20);
      ticks(256);
      settle();
      expect_w("ring_on", 1, 12'hDFE);
      expect_w("osc_last", -1, 12'h010);
      sample();
      ctrl[15:8] = 8'h10;
      settle();
      expect_w("ring_off", 1, 12'h200);
      sample();
      set_v(1, 16'h1000, 12'h200, 8'h60);
      settle();
      expect_w("and_pulse_lo", 1, 12'h000);
      sample();
      pw[23:12] = 12'h050;
      settle();
      expect_w("and_pulse_hi", 1, 12'h100);
      sample();

      // Noise: LFSR steps on the first bit19 rise (tick 16 at freq 0x8000).
      fresh();
      set_v(0, 16'h8000, 12'h000, 8'h48);
      settle();
      expect_w("noise_pre_test", 0, 12'hFFF);
      sample();
      ticks(2);
      ctrl[7:0] = 8'h80;
      ticks(15);
      settle();
`ifdef OSC_BANK_NOISE_EN
      expect_w("noise_seed", 0, 12'hFF0);
`else
      expect_w("noise_seed", 0, 12'h000);
`endif
      sample();
      ticks(1);
      settle();
`ifdef OSC_BANK_NOISE_EN
      expect_w("noise_step", 0, 12'hFE0);
`else
      expect_w("noise_step", 0, 12'h000);
`endif
      sample();
      ctrl[7:0] = 8'hA0;
      settle();
      expect_w("noise_saw", 0, 12'h080);
      sample();
      ctrl[7:0] = 8'h20;
      settle();
      expect_w("saw_only", 0, 12'h080);
      sample();

      // Reset mid-run, then restart from zero.
      en  = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_w("rst_mid_v0", 0, 12'h000);
      expect_w("rst_mid_last", -1, 12'h000);
      sample();
      rst = 1'b0;
      ticks(3);
      settle();
      expect_w("rst_restart", 0, 12'h018);
      sample();

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
